// File: rtl/bigint_stream_multiplier.sv
// Run-time-length schoolbook multiplier for multi-block unsigned integers.
// Operands stream in and the 2L-block product streams out, least-significant block first.
module bigint_stream_multiplier #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 4096,
  localparam int MAX_BLOCKS   = BITS_IN_NUM / REGISTER_SIZE,
  localparam int LEN_WIDTH    = $clog2(MAX_BLOCKS) + 1
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [REGISTER_SIZE-1:0] n_in,
  input  logic [REGISTER_SIZE-1:0] m_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  input  logic [LEN_WIDTH-1:0]     len_in,
  input  logic                     square_in,
  output logic [REGISTER_SIZE-1:0] data_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic                     last_out,
  output logic                     err_out,
  output logic [1:0]               state_out
);
  localparam int W     = REGISTER_SIZE;
  localparam int W2    = 2 * REGISTER_SIZE;
  localparam int OP_AW = LEN_WIDTH - 1;
  localparam int LW1   = LEN_WIDTH + 1;
  localparam int CYC_W = 2 * LEN_WIDTH + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, COMPUTE = 2'd2, DRAIN = 2'd3} state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] len_q, load_cnt, i_cnt, j_cnt, out_idx;
  logic                 square_q;
  logic [CYC_W-1:0]     cyc_cnt, steps_q;

  logic [W-1:0] a_mem   [MAX_BLOCKS];
  logic [W-1:0] b_mem   [MAX_BLOCKS];
  logic [W-1:0] acc_mem [2*MAX_BLOCKS];

  logic                 s1_valid, s2_valid, s3_valid;
  logic                 s1_flush, s2_flush;
  logic                 s1_first, s2_first, s3_first;
  logic [LEN_WIDTH-1:0] s1_k, s2_k, s3_k;
  logic [W-1:0]         s1_a, s1_b, s2_a, s2_b;
  logic [W2-1:0]        s3_prod;
  logic [W-1:0]         c_mul;
  logic                 c_add;

  logic                 accept, len_ok, wr_beat, issue, b_sel_n, cadd_in;
  logic [OP_AW-1:0]     wr_idx;
  logic [W-1:0]         b_data, cmul_in;
  logic [W2-1:0]        t_sum;
  logic [W:0]           acc_sum;
  logic [LEN_WIDTH-1:0] next_idx;
  logic [LEN_WIDTH:0]   last_idx;

  // Handshakes: a beat transfers on a rising edge where valid && ready are both high;
  // a producer holds valid and its data stable until that edge.
  assign ready_out = rst_n_in && (state == IDLE || state == LOAD);
  assign state_out = state;
  assign accept    = valid_in && ready_out;
  assign len_ok    = (len_in != '0) && (len_in <= LEN_WIDTH'(MAX_BLOCKS));
  assign wr_beat   = accept && ((state == LOAD) || len_ok);
  assign wr_idx    = (state == LOAD) ? load_cnt[OP_AW-1:0] : '0;
  assign b_sel_n   = (state == LOAD) ? square_q : square_in;
  assign b_data    = b_sel_n ? n_in : m_in;
  assign issue     = (state == COMPUTE) && (cyc_cnt < steps_q);
  assign next_idx  = out_idx + LEN_WIDTH'(1);
  assign last_idx  = {len_q, 1'b0} - LW1'(1);

  // Carries restart at i=0 of every pass; the flush step (a=0) empties both chains.
  assign cmul_in = s3_first ? '0 : c_mul;
  assign cadd_in = !s3_first && c_add;
  assign t_sum   = s3_prod + {{W{1'b0}}, cmul_in};
  assign acc_sum = {1'b0, acc_mem[s3_k]} + {1'b0, t_sum[W-1:0]} + {{W{1'b0}}, cadd_in};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      len_q     <= '0;
      square_q  <= 1'b0;
      load_cnt  <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      cyc_cnt   <= '0;
      steps_q   <= '0;
      out_idx   <= '0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      err_out   <= 1'b0;
    end else begin
      err_out  <= 1'b0;
      s1_valid <= issue;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!len_ok) begin
              err_out <= 1'b1;
            end else begin
              len_q    <= len_in;
              square_q <= square_in;
              load_cnt <= LEN_WIDTH'(1);
              steps_q  <= CYC_W'(len_in) * (CYC_W'(len_in) + CYC_W'(1));
              i_cnt    <= '0;
              j_cnt    <= '0;
              cyc_cnt  <= '0;
              state    <= (len_in == LEN_WIDTH'(1)) ? COMPUTE : LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            load_cnt <= load_cnt + LEN_WIDTH'(1);
            if (load_cnt == len_q - LEN_WIDTH'(1)) state <= COMPUTE;
          end
        end
        COMPUTE: begin
          cyc_cnt <= cyc_cnt + CYC_W'(1);
          if (issue) begin
            if (i_cnt == len_q) begin
              i_cnt <= '0;
              j_cnt <= j_cnt + LEN_WIDTH'(1);
            end else begin
              i_cnt <= i_cnt + LEN_WIDTH'(1);
            end
          end
          // Three spare cycles let the last accumulate retire before the drain starts.
          if (cyc_cnt == steps_q + CYC_W'(3)) begin
            state     <= DRAIN;
            out_idx   <= '0;
            data_out  <= acc_mem[0];
            valid_out <= 1'b1;
            last_out  <= 1'b0;
          end
        end
        DRAIN: begin
          if (ready_in) begin
            if (last_out) begin
              valid_out <= 1'b0;
              last_out  <= 1'b0;
              data_out  <= '0;
              state     <= IDLE;
            end else begin
              out_idx  <= next_idx;
              data_out <= acc_mem[next_idx];
              last_out <= ({1'b0, next_idx} == last_idx);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand storage with a two-register read path, followed by the registered multiply.
  always_ff @(posedge clk_in) begin
    if (wr_beat) begin
      a_mem[wr_idx] <= n_in;
      b_mem[wr_idx] <= b_data;
    end
    s1_a     <= a_mem[i_cnt[OP_AW-1:0]];
    s1_b     <= b_mem[j_cnt[OP_AW-1:0]];
    s1_flush <= (i_cnt == len_q);
    s1_first <= (i_cnt == '0);
    s1_k     <= i_cnt + j_cnt;
    s2_a     <= s1_a;
    s2_b     <= s1_b;
    s2_flush <= s1_flush;
    s2_first <= s1_first;
    s2_k     <= s1_k;
    s3_prod  <= s2_flush ? '0 : W2'(s2_a) * W2'(s2_b);
    s3_first <= s2_first;
    s3_k     <= s2_k;
    if (s3_valid) begin
      c_mul <= t_sum[W2-1:W];
      c_add <= acc_sum[W];
    end
  end

  // The accumulator is read at the accumulate stage itself, so the previous pass's
  // write to the same block (L cycles earlier) is always visible.
  always_ff @(posedge clk_in) begin
    if (s3_valid) begin
      acc_mem[s3_k] <= acc_sum[W-1:0];
    end else if (wr_beat) begin
      acc_mem[{wr_idx, 1'b0}] <= '0;
      acc_mem[{wr_idx, 1'b1}] <= '0;
    end
  end
endmodule

// File: tb/tb_bigint_stream_multiplier.sv
// Scoreboard bench for bigint_stream_multiplier: directed products, length errors,
// random stalls with a full-length operand, and reset abort mid-compute.
`timescale 1ns/1ps
module tb_bigint_stream_multiplier;
  localparam int W    = 32;
  localparam int MAXB = 128;
  localparam int LW   = 8;
  localparam int BIGW = 2 * MAXB * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  n_in, m_in, data_out;
  logic          valid_in, ready_out, square_in, valid_out, ready_in, last_out, err_out;
  logic [LW-1:0] len_in;
  logic [1:0]    dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  bigint_stream_multiplier dut (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .n_in      (n_in),
    .m_in      (m_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .len_in    (len_in),
    .square_in (square_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .last_out  (last_out),
    .err_out   (err_out),
    .state_out (dbg_state)
  );

  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  logic [W:0]   exp_q[$];
  int           lat_start_q[$];
  int           lat_exp_q[$];
  logic [W-1:0] na [MAXB];
  logic [W-1:0] ma [MAXB];
  bit           rand_ready = 1'b0;
  logic         prev_vo = 1'b0, prev_ri = 1'b0, prev_lo = 1'b0;
  logic [W-1:0] prev_d = '0;
  logic [W:0]   exp_w;
  int           lat_s, lat_e, last_beat_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic report();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vo = 1'b0;
      prev_ri = 1'b0;
    end else begin
      if (prev_vo && !prev_ri) begin
        check("stall_valid", valid_out, 1);
        check("stall_data", data_out, prev_d);
        check("stall_last", last_out, prev_lo);
      end
      if (valid_out && !prev_vo) begin
        if (lat_exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL drain_start: unexpected valid_out at cycle %0d", cyc);
        end else begin
          lat_s = lat_start_q.pop_front();
          lat_e = lat_exp_q.pop_front();
          check("compute_latency", cyc - lat_s, lat_e);
        end
      end
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL out_beat: unexpected beat %h last %b, expected none", data_out, last_out);
        end else begin
          exp_w = exp_q.pop_front();
          check("out_data", data_out, exp_w[W-1:0]);
          check("out_last", last_out, exp_w[W]);
        end
      end
      prev_vo = valid_out;
      prev_ri = ready_in;
      prev_d  = data_out;
      prev_lo = last_out;
    end
  end

  // driver tasks
  task automatic push_exp(input logic [W-1:0] word, input logic last);
    exp_q.push_back({last, word});
  endtask

  task automatic push_model(input int len, input bit sq);
    logic [BIGW-1:0] a, b, p;
    a = '0;
    b = '0;
    for (int k = 0; k < len; k++) begin
      a[k*W +: W] = na[k];
      b[k*W +: W] = sq ? na[k] : ma[k];
    end
    p = a * b;
    for (int k = 0; k < 2 * len; k++) exp_q.push_back({(k == 2 * len - 1), p[k*W +: W]});
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready_out) begin
      n++;
      if (n > 40000) begin
        tests++;
        fails++;
        $display("FAIL ready_timeout: ready_out stuck at 0, expected 1 (cycle %0d)", cyc);
        report();
      end
      @(negedge clk);
    end
  endtask

  task automatic drive_op(input int len, input bit sq, input bit gaps, input bit track);
    for (int k = 0; k < len; k++) begin
      if (gaps && k > 0) begin
        int idle = $urandom_range(0, 2);
        if (idle > 0) begin
          repeat (idle) @(posedge clk);
          #1;
        end
      end
      n_in      = na[k];
      m_in      = sq ? W'($urandom) : ma[k];
      len_in    = (k == 0) ? LW'(len) : LW'($urandom);
      square_in = (k == 0) ? sq : 1'($urandom_range(0, 1));
      valid_in  = 1'b1;
      wait_ready();
      last_beat_cyc = cyc;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
    end
    if (track) begin
      lat_start_q.push_back(last_beat_cyc);
      lat_exp_q.push_back(len * (len + 1) + 5);
    end
  endtask

  task automatic send_bad(input int len);
    n_in      = W'($urandom);
    m_in      = W'($urandom);
    len_in    = LW'(len);
    square_in = 1'b0;
    valid_in  = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    @(negedge clk);
    check("err_pulse", err_out, 1);
    check("err_ready", ready_out, 1);
    @(negedge clk);
    check("err_one_cycle", err_out, 0);
    check("err_no_valid", valid_out, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; valid_in = 1'b0; n_in = '0; m_in = '0;
    len_in = '0; square_in = 1'b0; ready_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", ready_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_last", last_out, 0);
    check("rst_data", data_out, 0);
    check("rst_err", err_out, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", ready_out, 1);
    @(posedge clk);
    #1;

    // L=1 all ones
    na[0] = 32'hFFFFFFFF; ma[0] = 32'hFFFFFFFF;
    push_exp(32'h00000001, 1'b0);
    push_exp(32'hFFFFFFFE, 1'b1);
    drive_op(1, 1'b0, 1'b0, 1'b1);

    // L=2 all ones
    na[0] = 32'hFFFFFFFF; na[1] = 32'hFFFFFFFF;
    ma[0] = 32'hFFFFFFFF; ma[1] = 32'hFFFFFFFF;
    push_exp(32'h00000001, 1'b0);
    push_exp(32'h00000000, 1'b0);
    push_exp(32'hFFFFFFFE, 1'b0);
    push_exp(32'hFFFFFFFF, 1'b1);
    drive_op(2, 1'b0, 1'b0, 1'b1);

    // square L=4 with garbage on m_in, then plain multiply L=4
    for (int k = 0; k < 4; k++) na[k] = W'($urandom);
    push_model(4, 1'b1);
    drive_op(4, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) ma[k] = W'($urandom);
    push_model(4, 1'b0);
    drive_op(4, 1'b0, 1'b0, 1'b1);

    // illegal lengths, then (2^32+1)^2 = blocks 1,2,1,0
    send_bad(0);
    send_bad(MAXB + 1);
    na[0] = 32'h1; na[1] = 32'h1; ma[0] = 32'h1; ma[1] = 32'h1;
    push_exp(32'h00000001, 1'b0);
    push_exp(32'h00000002, 1'b0);
    push_exp(32'h00000001, 1'b0);
    push_exp(32'h00000000, 1'b1);
    drive_op(2, 1'b0, 1'b0, 1'b1);

    // full length with input gaps and downstream stalls
    rand_ready = 1'b1;
    for (int k = 0; k < MAXB; k++) begin
      na[k] = W'($urandom);
      ma[k] = W'($urandom);
    end
    push_model(MAXB, 1'b0);
    drive_op(MAXB, 1'b0, 1'b1, 1'b1);

    // reset in the middle of an L=4 compute, then 3*5
    for (int k = 0; k < 4; k++) begin
      na[k] = W'($urandom);
      ma[k] = W'($urandom);
    end
    drive_op(4, 1'b0, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ready", ready_out, 0);
    check("abort_valid", valid_out, 0);
    check("abort_state", dbg_state, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_after", ready_out, 1);
    @(posedge clk);
    #1;
    na[0] = 32'd3; na[1] = 32'd0; ma[0] = 32'd5; ma[1] = 32'd0;
    push_exp(32'd15, 1'b0);
    push_exp(32'd0, 1'b0);
    push_exp(32'd0, 1'b0);
    push_exp(32'd0, 1'b1);
    drive_op(2, 1'b0, 1'b0, 1'b1);

    n = 0;
    while ((exp_q.size() != 0 || lat_exp_q.size() != 0) && n < 50000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("drain_done_beats", exp_q.size(), 0);
    check("drain_done_starts", lat_exp_q.size(), 0);
    report();
  end
endmodule
